seq_checker: RTL and testbench

- Receive-side monitor for the 3-bit autonomous state sequence produced by the team's Activity 3 sequence generator.
- Samples the generator's state code each valid cycle and hunts for the start code (S0).
- Tracks the sequence against the fixed transition table and asserts lock after a run of correct transitions.
- Once locked, flags and counts every deviation; sits beside the generator on the board and drives status LEDs / debug outputs.

---
 rtl/seq_checker.sv | 99 +++++++++
 tb/tb_seq_checker.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seq_checker.sv
// Lock/deviation monitor for the 3-bit generator state stream; outputs registered, 1-cycle latency.
// No backpressure: obs_valid low simply freezes all state and suppresses the err/start_seen pulses.
module seq_checker #(
  parameter int LOCK_N   = 3,
  parameter int UNLOCK_N = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             obs_valid,
  input  logic [2:0]       obs_state,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic             start_seen,
  output logic [2:0]       exp_state
);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

  localparam logic [3:0] LOCK_V   = 4'(LOCK_N);
  localparam logic [3:0] UNLOCK_V = 4'(UNLOCK_N);

  state_t     state;
  logic [3:0] match_cnt;
  logic [3:0] miss_cnt;

  function automatic logic [2:0] next_code(input logic [2:0] s);
    case (s)
      3'd0:    next_code = 3'd4;
      3'd1:    next_code = 3'd2;
      3'd2:    next_code = 3'd1;
      3'd3:    next_code = 3'd3;
      3'd4:    next_code = 3'd7;
      default: next_code = 3'd2;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      match_cnt  <= 4'd0;
      miss_cnt   <= 4'd0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
      start_seen <= 1'b0;
      exp_state  <= 3'd0;
    end else begin
      err        <= 1'b0;
      start_seen <= 1'b0;
      if (obs_valid) begin
        start_seen <= (obs_state == 3'd0);
        case (state)
          HUNT: begin
            if (obs_state == 3'd0) begin
              state     <= TRACK;
              exp_state <= 3'd4;
              match_cnt <= 4'd0;
            end
          end
          TRACK: begin
            if (obs_state == exp_state) begin
              match_cnt <= match_cnt + 4'd1;
              exp_state <= next_code(obs_state);
              if (match_cnt + 4'd1 == LOCK_V) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= 4'd0;
              end
            end else if (obs_state == 3'd0) begin
              // A fresh start code restarts the run instead of dropping to HUNT
              exp_state <= 3'd4;
              match_cnt <= 4'd0;
            end else begin
              state <= HUNT;
            end
          end
          LOCKED: begin
            exp_state <= next_code(obs_state);
            if (obs_state == exp_state) begin
              miss_cnt <= 4'd0;
            end else begin
              err      <= 1'b1;
              miss_cnt <= miss_cnt + 4'd1;
              if (err_count != '1) err_count <= err_count + CNT_W'(1);
              if (miss_cnt + 4'd1 == UNLOCK_V) begin
                state  <= HUNT;
                locked <= 1'b0;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_checker.sv
// Directed-vector scoreboard bench for seq_checker (LOCK_N=3, UNLOCK_N=2, CNT_W=2).
module tb_seq_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       obs_valid = 1'b0;
  logic [2:0] obs_state = 3'd0;
  logic       locked, err, start_seen;
  logic [1:0] err_count;
  logic [2:0] exp_state;

  typedef struct {
    int         idx;
    logic       l;
    logic       e;
    logic [1:0] c;
    logic       s;
    logic [2:0] x;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int step_no = 0;

  seq_checker #(.LOCK_N(3), .UNLOCK_N(2), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .obs_valid(obs_valid), .obs_state(obs_state),
    .locked(locked), .err(err), .err_count(err_count),
    .start_seen(start_seen), .exp_state(exp_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL step %0d %s: got %0d expected %0d", idx, name, act, req);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after its edge
  task automatic step(input logic r, input logic v, input logic [2:0] st,
                      input logic l, input logic e, input logic [1:0] c,
                      input logic s, input logic [2:0] x);
    exp_t t;
    @(negedge clk);
    reset = r;
    obs_valid = v;
    obs_state = st;
    t.idx = step_no; t.l = l; t.e = e; t.c = c; t.s = s; t.x = x;
    q.push_back(t);
    step_no++;
  endtask

  always @(posedge clk) begin
    exp_t t;
    #1;
    if (q.size() > 0) begin
      t = q.pop_front();
      chk("locked", t.idx, int'(locked), int'(t.l));
      chk("err", t.idx, int'(err), int'(t.e));
      chk("err_count", t.idx, int'(err_count), int'(t.c));
      chk("start_seen", t.idx, int'(start_seen), int'(t.s));
      chk("exp_state", t.idx, int'(exp_state), int'(t.x));
    end
  end

  initial begin
    //    rst v  st   L  E  C  S  X
    step(1, 0, 0,   0, 0, 0, 0, 0);
    // Acquire lock on the generator stream 0,4,7,2
    step(0, 1, 0,   0, 0, 0, 1, 4);
    step(0, 1, 4,   0, 0, 0, 0, 7);
    step(0, 1, 7,   0, 0, 0, 0, 2);
    step(0, 1, 2,   1, 0, 0, 0, 1);
    for (int i = 0; i < 48; i++) begin
      step(0, 1, 1, 1, 0, 0, 0, 2);
      step(0, 1, 2, 1, 0, 0, 0, 1);
    end
    // Single glitch: 5 in place of 2
    step(0, 1, 1,   1, 0, 0, 0, 2);
    step(0, 1, 5,   1, 1, 1, 0, 2);
    step(0, 1, 2,   1, 0, 1, 0, 1);
    step(0, 1, 1,   1, 0, 1, 0, 2);
    // Two consecutive mismatches drop lock
    step(0, 1, 2,   1, 0, 1, 0, 1);
    step(0, 1, 1,   1, 0, 1, 0, 2);
    step(0, 1, 6,   1, 1, 2, 0, 2);
    step(0, 1, 0,   0, 1, 3, 1, 4);
    // Now in HUNT: non-zero samples leave exp_state alone
    step(0, 1, 4,   0, 0, 3, 0, 4);
    step(0, 1, 7,   0, 0, 3, 0, 4);
    // Reset beats a valid start code
    step(1, 1, 0,   0, 0, 0, 0, 0);
    // Mismatch in TRACK, then restart via 0 inside TRACK
    step(0, 1, 0,   0, 0, 0, 1, 4);
    step(0, 1, 4,   0, 0, 0, 0, 7);
    step(0, 1, 3,   0, 0, 0, 0, 7);
    step(0, 1, 0,   0, 0, 0, 1, 4);
    step(0, 1, 4,   0, 0, 0, 0, 7);
    step(0, 1, 0,   0, 0, 0, 1, 4);
    step(0, 1, 4,   0, 0, 0, 0, 7);
    step(0, 1, 7,   0, 0, 0, 0, 2);
    step(0, 1, 2,   1, 0, 0, 0, 1);
    // Lock with 3-cycle obs_valid gaps (obs_state=0 while invalid)
    step(1, 0, 0,   0, 0, 0, 0, 0);
    step(0, 1, 0,   0, 0, 0, 1, 4);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 4);
    step(0, 1, 4,   0, 0, 0, 0, 7);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 7);
    step(0, 1, 7,   0, 0, 0, 0, 2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 2);
    step(0, 1, 2,   1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 5, 1, 0, 0, 0, 1);
    // Five non-consecutive mismatches while locked: count saturates at 3
    step(0, 1, 5,   1, 1, 1, 0, 2);
    step(0, 1, 2,   1, 0, 1, 0, 1);
    step(0, 1, 3,   1, 1, 2, 0, 3);
    step(0, 1, 3,   1, 0, 2, 0, 3);
    step(0, 1, 0,   1, 1, 3, 1, 4);
    step(0, 1, 4,   1, 0, 3, 0, 7);
    step(0, 1, 6,   1, 1, 3, 0, 2);
    step(0, 1, 2,   1, 0, 3, 0, 1);
    step(0, 1, 5,   1, 1, 3, 0, 2);
    // Mid-lock reset clears everything; DUT is back in HUNT
    step(1, 1, 0,   0, 0, 0, 0, 0);
    step(0, 0, 0,   0, 0, 0, 0, 0);
    step(0, 1, 4,   0, 0, 0, 0, 0);
    step(0, 1, 0,   0, 0, 0, 1, 4);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
